// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame header width, word packing geometry and the loader FSM encoding.
package imem_loader_pkg;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; strobes on the 4th byte.
// The completed word is presented combinationally alongside the strobe.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [IDX_W-1:0] idx_q;
  logic [23:0]      lanes_q;

  assign word_complete_o = accept_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  // The top lane never needs storage: it is the byte arriving with the strobe.
  assign word_o          = {byte_i, lanes_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else if (clear_i) begin
      idx_q   <= '0;
    end else if (accept_i) begin
      idx_q <= idx_q + IDX_W'(1);
      case (idx_q)
        2'd0:    lanes_q[7:0]   <= byte_i;
        2'd1:    lanes_q[15:8]  <= byte_i;
        2'd2:    lanes_q[23:16] <= byte_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted byte frame, writes packed words to instruction
// memory and holds the core in reset until the last write has been issued.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  state_t            state_q, state_d;
  logic [HDR_W-1:0]  n_q, n_d;
  logic [15:0]       words_q, words_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_reset_q, cpu_reset_d;

  logic              accept;
  logic              rearm;
  logic              pk_accept;
  logic              pk_clear;
  logic [31:0]       pk_word;
  logic              pk_complete;
  logic [HDR_W-1:0]  hdr_n;

  assign accept    = s_valid && s_ready_q;
  assign hdr_n     = {s_data, n_q[7:0]};
  assign pk_accept = accept && (state_q == ST_DATA);
  assign pk_clear  = (accept && (state_q == ST_HDR_HI)) || rearm;

  imem_loader_byte_packer u_packer (
    .clk             (clk),
    .reset           (reset),
    .accept_i        (pk_accept),
    .clear_i         (pk_clear),
    .byte_i          (s_data),
    .word_o          (pk_word),
    .word_complete_o (pk_complete)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    rearm   = 1'b0;
    case (state_q)
      ST_HDR_LO: begin
        if (accept) begin
          n_d     = {n_q[15:8], s_data};
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (accept) begin
          n_d = hdr_n;
          if (hdr_n == '0)                                state_d = ST_DONE;
          else if ({16'd0, hdr_n} > 32'(DEPTH_WORDS))     state_d = ST_ERROR;
          else                                            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_complete) begin
          we_d    = 1'b1;
          wdata_d = pk_word;
          addr_d  = BASE_ADDR + 32'(words_q) * 32'(BYTES_PER_WORD);
          words_d = words_q + 16'd1;
          if ((words_q + 16'd1) == n_q) state_d = ST_FLUSH;
        end
      end
      // One idle cycle so the final write lands before the core leaves reset.
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE, ST_ERROR: begin
        if (start) begin
          rearm   = 1'b1;
          state_d = ST_HDR_LO;
          words_d = '0;
          addr_d  = BASE_ADDR;
        end
      end
      default: state_d = ST_HDR_LO;
    endcase

    s_ready_d   = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) || (state_d == ST_DATA);
    busy_d      = s_ready_d || (state_d == ST_FLUSH);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    cpu_reset_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HDR_LO;
      n_q         <= '0;
      words_q     <= '0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      s_ready_q   <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench for imem_loader with a frame-level reference model.
module tb_imem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, imem_we, cpu_reset, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] got_addr[$], got_data[$];

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int frame_n();
    return int'(frame[0]) + 256 * int'(frame[1]);
  endfunction

  // Expected writes follow directly from the frame: word i is bytes 2+4i..5+4i, LE.
  task automatic build_model();
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = frame_n();
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back({frame[5 + 4*i], frame[4 + 4*i], frame[3 + 4*i], frame[2 + 4*i]});
      end
    end
  endtask

  task automatic make_frame(input int n);
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    if (n >= 1 && n <= DEPTH)
      for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
  endtask

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      if (g == 0) check("busy_in_gap", 32'(busy), 32'd1);
    end
    s_valid = 1'b1;
    s_data  = b;
    cnt = 0;
    while (!s_ready && cnt < 50) begin
      @(posedge clk); @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap_max);
    int n;
    build_model();
    got_addr.delete();
    got_data.delete();
    n = frame_n();
    for (int i = 0; i < frame.size(); i++)
      send_byte(frame[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
    if (n == 0) begin
      check("n0_done", 32'(done), 32'd1);
      check("n0_cpu_reset", 32'(cpu_reset), 32'd0);
      check("n0_busy", 32'(busy), 32'd0);
    end else if (n > DEPTH) begin
      check("err_flag", 32'(error), 32'd1);
      check("err_ready", 32'(s_ready), 32'd0);
      check("err_cpu_reset", 32'(cpu_reset), 32'd1);
      check("err_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
    end else begin
      check("flush_ready", 32'(s_ready), 32'd0);
      check("flush_cpu_reset", 32'(cpu_reset), 32'd1);
      check("flush_done", 32'(done), 32'd0);
      @(posedge clk); @(negedge clk);
      check("done_cpu_reset", 32'(cpu_reset), 32'd0);
      check("done_flag", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
    end
    check("n_writes", 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check("wr_addr", got_addr[i], exp_addr[i]);
      check("wr_data", got_data[i], exp_data[i]);
    end
    check("words_loaded", 32'(words_loaded), 32'(exp_addr.size()));
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("rearm_ready", 32'(s_ready), 32'd1);
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_error", 32'(error), 32'd0);
    check("rearm_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rearm_words", 32'(words_loaded), 32'd0);
    check("rearm_addr", imem_addr, BASE);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, imem_addr, BASE);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic load_directed();
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    frame.delete();
    for (int i = 0; i < 10; i++) frame.push_back(img[i]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Directed two-word image, back-to-back.
    load_directed();
    run_frame(0);
    if (got_data.size() >= 2) begin
      check("dir_w0", got_data[0], 32'h0050_0013);
      check("dir_a1", got_addr[1], 32'h0000_0004);
      check("dir_w1", got_data[1], 32'h00A0_0093);
    end else check("dir_count", 32'(got_data.size()), 32'd2);

    // Traffic after DONE must be ignored.
    s_valid = 1'b1;
    s_data  = 8'hFF;
    got_addr.delete();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      check("post_ready", 32'(s_ready), 32'd0);
      check("post_we", 32'(imem_we), 32'd0);
      check("post_words", 32'(words_loaded), 32'd2);
    end
    s_valid = 1'b0;
    rearm();

    // Same image with 3-cycle gaps between every byte.
    load_directed();
    frame = frame;
    build_model();
    got_addr.delete();
    got_data.delete();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 3);
    @(posedge clk); @(negedge clk);
    check("gap_done", 32'(done), 32'd1);
    check("gap_writes", 32'(got_data.size()), 32'd2);
    for (int i = 0; i < 2 && i < got_data.size(); i++) begin
      check("gap_addr", got_addr[i], exp_addr[i]);
      check("gap_data", got_data[i], exp_data[i]);
    end
    rearm();

    // Oversized header, then empty frame.
    frame.delete(); frame.push_back(8'h01); frame.push_back(8'h01);
    run_frame(0);
    rearm();
    frame.delete(); frame.push_back(8'h00); frame.push_back(8'h00);
    run_frame(0);
    rearm();

    // Reset in the middle of the second word, then a full resend.
    load_directed();
    for (int i = 0; i < 7; i++) send_byte(frame[i], 0);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(0);
    rearm();

    // Full-capacity image.
    make_frame(DEPTH);
    run_frame(1);
    if (got_addr.size() == DEPTH) check("last_addr", got_addr[DEPTH-1], BASE + 32'h3FC);
    rearm();

    // Randomized frames.
    for (int r = 0; r < 30; r++) begin
      int kind;
      int n;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      n = 0;
      else if (kind == 1) n = int'($urandom_range(DEPTH + 1, 65535));
      else if (kind == 2) n = DEPTH + 1;
      else                n = int'($urandom_range(1, 6));
      make_frame(n);
      run_frame(int'($urandom_range(0, 2)));
      rearm();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle core fetches from.
- Receives a framed little-endian byte stream over a valid/ready interface and packs it into 32-bit words.
- Writes each word to the instruction memory's write port at consecutive word-aligned byte addresses.
- Holds the core in reset until the whole image is written, then releases it.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; upper bound for the header count.
BASE_ADDR, 32'h0000_0000, byte address written for word 0; must be word aligned.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
s_valid  input  1  byte-stream valid.
s_data  input  8  byte-stream data.
s_ready  output  1  loader can accept a byte.
imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
imem_addr  output  32  byte address of the word being written.
imem_wdata  output  32  packed instruction word.
cpu_reset  output  1  active-high reset to the core.
busy  output  1  loader is in HDR_LO, HDR_HI, DATA or FLUSH.
done  output  1  image fully written and core released.
error  output  1  header count exceeded DEPTH_WORDS.
words_loaded  output  16  number of words written so far.

Behaviour:
- Reset (asynchronous) forces the following, regardless of current state, including mid-load:
  - state=HDR_LO, s_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_reset=1, busy=1, done=0, error=0, words_loaded=0.
  - Byte index and word count are cleared.
  - Words already written to memory are left untouched.
- All outputs are registered.
- A byte is accepted on a rising edge where s_valid && s_ready.
- Frame format: 16-bit word count N (low byte first), followed by 4*N data bytes.
  - Data is little-endian: the first byte of a word goes to wdata[7:0], the fourth to wdata[31:24].
- States:
  - HDR_LO: s_ready=1. On accept, latch N[7:0] and go to HDR_HI.
  - HDR_HI: s_ready=1. On accept, latch N[15:8], then:
    - if N==0, go to DONE;
    - if N>DEPTH_WORDS, go to ERROR;
    - otherwise go to DATA.
  - DATA: s_ready=1.
    - Each accepted byte fills a lane selected by a 2-bit byte index (0..3); the index wraps 3->0.
    - On the edge accepting byte 3 of word i:
      - imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+4*i, imem_wdata=the packed word.
      - words_loaded becomes i+1 on the same edge.
    - If i+1==N, go to FLUSH; otherwise stay in DATA.
    - There is no back-pressure inside a word; bytes may arrive on consecutive cycles with no stalls.
  - FLUSH: s_ready=0, imem_we=0. Lasts one cycle, then go to DONE.
  - DONE: s_ready=0, cpu_reset=0, done=1, busy=0. Incoming s_valid is ignored.
  - ERROR: s_ready=0, cpu_reset=1, error=1, busy=0.
- Re-arm: start in DONE or ERROR moves to HDR_LO on the next edge.
  - Sets cpu_reset=1, clears done, error, words_loaded, byte index, and sets imem_addr=BASE_ADDR.
  - start in any other state is ignored.
- cpu_reset falls on the same edge that enters DONE, which is two edges after the final byte is accepted.
  - This guarantees the last imem_we completes before the core fetches.
- Gaps in s_valid are allowed anywhere; the state and byte index simply hold.
- imem_addr increments by 4 per word. It cannot exceed BASE_ADDR+4*(DEPTH_WORDS-1) because of the header check.
- A header of N==DEPTH_WORDS is legal and fills memory exactly.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (HDR_LO, HDR_HI, DATA, FLUSH, DONE, ERROR);
  - the header width constant (16);
  - the bytes-per-word constant (4).
- Sub-module byte_packer: 2-bit byte index, 32-bit shift/lane register, and a word_complete strobe. The top-level FSM drives its accept and clear inputs.

Test Plan:
- Stream 02 00 13 00 50 00 93 00 A0 00 back-to-back ->
  - imem_we pulses carrying 0x00500013@0x0 and 0x00A00093@0x4;
  - words_loaded=2;
  - cpu_reset falls two edges after the last byte; done=1.
- Same image with s_valid deasserted for 3 cycles between every byte -> identical writes and values; busy stays 1 throughout the gaps.
- Header 01 01 (N=257, DEPTH_WORDS=256) -> ERROR, error=1, s_ready=0, cpu_reset=1, no imem_we. A start pulse then returns the loader to HDR_LO.
- Header 00 00 -> DONE on the edge accepting the second header byte, with no writes and cpu_reset=0.
- Assert reset after 5 data bytes of a 2-word image ->
  - all outputs return to reset values immediately;
  - resending the full frame writes both words correctly, starting at 0x0.
- After DONE, drive s_valid=1 with byte 0xFF for 10 cycles -> s_ready=0, no imem_we, words_loaded unchanged.
